// File: rtl/e_gpu_pkg.sv
// rtl/e_gpu_pkg.sv - shared defaults, derived widths and request layout for l2_req_merge
package e_gpu_pkg;

    localparam int L2M_NUM_INPUTS   = 8;
    localparam int L2M_NUM_OUTPUTS  = 2;
    localparam int L2M_DATA_WIDTH   = 512;
    localparam int L2M_ADDR_WIDTH   = 26;
    localparam int L2M_TAG_IN_WIDTH = 52;

    function automatic int sel_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    localparam int L2M_K             = L2M_NUM_INPUTS / L2M_NUM_OUTPUTS;
    localparam int L2M_SEL_W         = sel_width(L2M_K);
    localparam int L2M_TAG_OUT_WIDTH = L2M_TAG_IN_WIDTH + L2M_SEL_W;

    // Field order matches the packed payload carried through the skid buffers (rw is MSB).
    typedef struct packed {
        logic                          rw;
        logic [L2M_DATA_WIDTH/8-1:0]   byteen;
        logic [L2M_ADDR_WIDTH-1:0]     addr;
        logic [L2M_DATA_WIDTH-1:0]     data;
        logic [L2M_TAG_IN_WIDTH-1:0]   tag;
    } req_t;

endpackage

// File: rtl/rr_arb_skid.sv
// rtl/rr_arb_skid.sv - K-input round-robin arbiter feeding a 2-entry request buffer
module rr_arb_skid
    import e_gpu_pkg::*;
#(
    parameter int K  = 4,
    parameter int PW = 8,
    localparam int SEL_W = sel_width(K),
    localparam int EW    = PW + SEL_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [K-1:0]    req_valid,
    input  logic [K*PW-1:0] req_payload,
    output logic [K-1:0]    req_ready,
    output logic            out_valid,
    output logic [EW-1:0]   out_payload,
    input  logic            out_ready
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] cand;
    logic             any_valid;
    logic             accept;
    logic             drain;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             space_q;
    logic             wr_q;
    logic             rd_q;
    logic [EW-1:0]    mem_q [2];

    // Search starts one past the last accepted input so every requester gets a turn.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int j = 1; j <= K; j++) begin
            cand = SEL_W'((int'(ptr_q) + j) % K);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept    = any_valid & space_q;
    assign drain     = (count_q != 2'd0) & out_ready;
    assign count_d   = count_q + {1'b0, accept} - {1'b0, drain};
    assign out_valid = (count_q != 2'd0);
    assign out_payload = mem_q[rd_q];

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < K; i++) begin
            req_ready[i] = accept && (grant_idx == SEL_W'(i));
        end
    end

    // space_q mirrors (count < 2) one cycle ahead so the ready path stays flop-driven.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= SEL_W'(K - 1);
            count_q <= 2'd0;
            space_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            space_q <= (count_d < 2'd2);
            if (accept) begin
                ptr_q <= grant_idx;
                wr_q  <= ~wr_q;
            end
            if (drain) begin
                rd_q <= ~rd_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_q] <= {req_payload[grant_idx*PW +: PW], grant_idx};
        end
    end

endmodule

// File: rtl/l2_req_merge.sv
// rtl/l2_req_merge.sv - merges requester channels onto L2 ports and routes responses back by tag
module l2_req_merge
    import e_gpu_pkg::*;
#(
    parameter int NUM_INPUTS   = L2M_NUM_INPUTS,
    parameter int NUM_OUTPUTS  = L2M_NUM_OUTPUTS,
    parameter int DATA_WIDTH   = L2M_DATA_WIDTH,
    parameter int ADDR_WIDTH   = L2M_ADDR_WIDTH,
    parameter int TAG_IN_WIDTH = L2M_TAG_IN_WIDTH,
    localparam int K             = NUM_INPUTS / NUM_OUTPUTS,
    localparam int SEL_W         = sel_width(K),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_W
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_INPUTS-1:0]                 in_req_valid,
    input  logic [NUM_INPUTS-1:0]                 in_req_rw,
    input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0]    in_req_byteen,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]      in_req_addr,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]      in_req_data,
    input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]    in_req_tag,
    output logic [NUM_INPUTS-1:0]                 in_req_ready,
    output logic [NUM_INPUTS-1:0]                 in_rsp_valid,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]      in_rsp_data,
    output logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]    in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                 in_rsp_ready,
    output logic [NUM_OUTPUTS-1:0]                out_req_valid,
    output logic [NUM_OUTPUTS-1:0]                out_req_rw,
    output logic [NUM_OUTPUTS*DATA_WIDTH/8-1:0]   out_req_byteen,
    output logic [NUM_OUTPUTS*ADDR_WIDTH-1:0]     out_req_addr,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]     out_req_data,
    output logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0]  out_req_tag,
    input  logic [NUM_OUTPUTS-1:0]                out_req_ready,
    input  logic [NUM_OUTPUTS-1:0]                out_rsp_valid,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]     out_rsp_data,
    input  logic [NUM_OUTPUTS*TAG_OUT_WIDTH-1:0]  out_rsp_tag,
    output logic [NUM_OUTPUTS-1:0]                out_rsp_ready
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = 1 + BW + ADDR_WIDTH + DATA_WIDTH + TAG_IN_WIDTH;
    localparam int EW = PW + SEL_W;

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_port
        logic [K*PW-1:0]  grp_payload;
        logic [EW-1:0]    head;
        logic [SEL_W-1:0] rsp_sel;
        logic [K-1:0]     rsp_hit;

        for (genvar l = 0; l < K; l++) begin : g_lane
            localparam int I = g * K + l;

            assign grp_payload[l*PW +: PW] = {in_req_rw[I],
                                              in_req_byteen[I*BW +: BW],
                                              in_req_addr[I*ADDR_WIDTH +: ADDR_WIDTH],
                                              in_req_data[I*DATA_WIDTH +: DATA_WIDTH],
                                              in_req_tag[I*TAG_IN_WIDTH +: TAG_IN_WIDTH]};

            assign rsp_hit[l]     = (rsp_sel == SEL_W'(l));
            assign in_rsp_valid[I] = out_rsp_valid[g] & rsp_hit[l];
            assign in_rsp_data[I*DATA_WIDTH +: DATA_WIDTH] = out_rsp_data[g*DATA_WIDTH +: DATA_WIDTH];
            assign in_rsp_tag[I*TAG_IN_WIDTH +: TAG_IN_WIDTH] =
                out_rsp_tag[g*TAG_OUT_WIDTH + SEL_W +: TAG_IN_WIDTH];
        end

        rr_arb_skid #(
            .K  (K),
            .PW (PW)
        ) u_arb (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req_valid   (in_req_valid[g*K +: K]),
            .req_payload (grp_payload),
            .req_ready   (in_req_ready[g*K +: K]),
            .out_valid   (out_req_valid[g]),
            .out_payload (head),
            .out_ready   (out_req_ready[g])
        );

        // The buffered source index sits below the requester tag, giving {tag, l} for free.
        assign out_req_tag[g*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] = head[TAG_OUT_WIDTH-1:0];
        assign out_req_data[g*DATA_WIDTH +: DATA_WIDTH]      = head[TAG_OUT_WIDTH +: DATA_WIDTH];
        assign out_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]      = head[TAG_OUT_WIDTH+DATA_WIDTH +: ADDR_WIDTH];
        assign out_req_byteen[g*BW +: BW]                    = head[TAG_OUT_WIDTH+DATA_WIDTH+ADDR_WIDTH +: BW];
        assign out_req_rw[g]                                 = head[EW-1];

        assign rsp_sel          = out_rsp_tag[g*TAG_OUT_WIDTH +: SEL_W];
        assign out_rsp_ready[g] = |(rsp_hit & in_rsp_ready[g*K +: K]);

        if (K != (1 << SEL_W)) begin : g_sel_chk
            always_ff @(posedge clk_i) begin
                if (rst_ni && out_rsp_valid[g]) begin
                    assert (int'(rsp_sel) < K);
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_req_merge.sv
// tb/tb_l2_req_merge.sv - directed self-checking bench for l2_req_merge
module tb_l2_req_merge;

    localparam int NI  = 8;
    localparam int NO  = 2;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int TW  = 16;
    localparam int SW  = 2;
    localparam int TOW = TW + SW;
    localparam int BW  = DW / 8;

    logic              clk_i;
    logic              rst_ni;
    logic [NI-1:0]     in_req_valid;
    logic [NI-1:0]     in_req_rw;
    logic [NI*BW-1:0]  in_req_byteen;
    logic [NI*AW-1:0]  in_req_addr;
    logic [NI*DW-1:0]  in_req_data;
    logic [NI*TW-1:0]  in_req_tag;
    logic [NI-1:0]     in_req_ready;
    logic [NI-1:0]     in_rsp_valid;
    logic [NI*DW-1:0]  in_rsp_data;
    logic [NI*TW-1:0]  in_rsp_tag;
    logic [NI-1:0]     in_rsp_ready;
    logic [NO-1:0]     out_req_valid;
    logic [NO-1:0]     out_req_rw;
    logic [NO*BW-1:0]  out_req_byteen;
    logic [NO*AW-1:0]  out_req_addr;
    logic [NO*DW-1:0]  out_req_data;
    logic [NO*TOW-1:0] out_req_tag;
    logic [NO-1:0]     out_req_ready;
    logic [NO-1:0]     out_rsp_valid;
    logic [NO*DW-1:0]  out_rsp_data;
    logic [NO*TOW-1:0] out_rsp_tag;
    logic [NO-1:0]     out_rsp_ready;

    int checks   = 0;
    int failures = 0;

    l2_req_merge #(
        .NUM_INPUTS   (NI),
        .NUM_OUTPUTS  (NO),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .TAG_IN_WIDTH (TW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_req_valid   (in_req_valid),
        .in_req_rw      (in_req_rw),
        .in_req_byteen  (in_req_byteen),
        .in_req_addr    (in_req_addr),
        .in_req_data    (in_req_data),
        .in_req_tag     (in_req_tag),
        .in_req_ready   (in_req_ready),
        .in_rsp_valid   (in_rsp_valid),
        .in_rsp_data    (in_rsp_data),
        .in_rsp_tag     (in_rsp_tag),
        .in_rsp_ready   (in_rsp_ready),
        .out_req_valid  (out_req_valid),
        .out_req_rw     (out_req_rw),
        .out_req_byteen (out_req_byteen),
        .out_req_addr   (out_req_addr),
        .out_req_data   (out_req_data),
        .out_req_tag    (out_req_tag),
        .out_req_ready  (out_req_ready),
        .out_rsp_valid  (out_rsp_valid),
        .out_rsp_data   (out_rsp_data),
        .out_rsp_tag    (out_rsp_tag),
        .out_rsp_ready  (out_rsp_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [TW-1:0] t);
        in_req_valid[i]           = v;
        in_req_rw[i]              = t[0];
        in_req_byteen[i*BW +: BW] = t[3:0];
        in_req_addr[i*AW +: AW]   = 26'h100000 + AW'(t);
        in_req_data[i*DW +: DW]   = {16'hDA7A, t};
        in_req_tag[i*TW +: TW]    = t;
    endtask

    function automatic logic [TOW-1:0] out_tag(input int g);
        return out_req_tag[g*TOW +: TOW];
    endfunction

    task automatic init_inputs;
        in_req_valid  = '0;
        in_req_rw     = '0;
        in_req_byteen = '0;
        in_req_addr   = '0;
        in_req_data   = '0;
        in_req_tag    = '0;
        in_rsp_ready  = '1;
        out_req_ready = '1;
        out_rsp_valid = '0;
        out_rsp_data  = '0;
        out_rsp_tag   = '0;
    endtask

    task automatic do_reset;
        init_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        init_inputs();
        rst_ni = 1'b0;
        set_req(0, 1'b1, 16'h0001);
        tick();
        tick();
        checks++;
        if (in_req_ready !== 8'h00) begin
            failures++;
            $display("FAIL reset_in_ready got=%h exp=00", in_req_ready);
        end
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=00", out_req_valid);
        end
        set_req(0, 1'b0, 16'h0000);
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (out_req_valid !== 2'b00) begin
                failures++;
                $display("FAIL idle_out_valid cyc=%0d got=%b exp=00", c, out_req_valid);
            end
        end
        set_req(0, 1'b1, 16'h1234);
        #1;
        checks++;
        if (in_req_ready !== 8'h01) begin
            failures++;
            $display("FAIL first_ready got=%h exp=01", in_req_ready);
        end
        tick();
        set_req(0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (out_req_valid !== 2'b01) begin
            failures++;
            $display("FAIL first_out_valid got=%b exp=01", out_req_valid);
        end
        checks++;
        if (out_tag(0) !== {16'h1234, 2'b00}) begin
            failures++;
            $display("FAIL first_out_tag got=%h exp=%h", out_tag(0), {16'h1234, 2'b00});
        end
        checks++;
        if (out_req_addr[AW-1:0] !== 26'h101234 || out_req_data[DW-1:0] !== 32'hDA7A1234) begin
            failures++;
            $display("FAIL first_out_payload got=%h/%h exp=101234/da7a1234", out_req_addr[AW-1:0], out_req_data[DW-1:0]);
        end
        tick();
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL first_drained got=%b exp=00", out_req_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [TW-1:0] cur [4];
        logic [TW-1:0] prev_tag;
        int            prev_l;
        do_reset();
        prev_tag = '0;
        prev_l   = 0;
        for (int i = 0; i < 4; i++) begin
            cur[i] = 16'h0100 + 16'(i);
            set_req(i, 1'b1, cur[i]);
        end
        for (int c = 0; c <= 5; c++) begin
            #1;
            if (c < 5) begin
                checks++;
                if (in_req_ready !== 8'(1 << (c % 4))) begin
                    failures++;
                    $display("FAIL rr_grant cyc=%0d got=%h exp=%h", c, in_req_ready, 8'(1 << (c % 4)));
                end
            end
            if (c > 0) begin
                checks++;
                if (out_req_valid[0] !== 1'b1 || out_tag(0) !== {prev_tag, SW'(prev_l)}) begin
                    failures++;
                    $display("FAIL rr_out cyc=%0d got=%b/%h exp=1/%h", c, out_req_valid[0], out_tag(0), {prev_tag, SW'(prev_l)});
                end
            end
            if (c < 5) begin
                prev_tag = cur[c % 4];
                prev_l   = c % 4;
                tick();
                cur[c % 4] = cur[c % 4] + 16'h0010;
                set_req(c % 4, 1'b1, cur[c % 4]);
            end
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'h0000);
        checks++;
        if (out_req_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL rr_other_port got=%b exp=0", out_req_valid[1]);
        end
        tick();
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL rr_drained got=%b exp=00", out_req_valid);
        end
    endtask

    task automatic test_full;
        do_reset();
        out_req_ready[0] = 1'b0;
        set_req(0, 1'b1, 16'hA000);
        set_req(1, 1'b1, 16'hA001);
        set_req(2, 1'b1, 16'hA002);
        #1;
        checks++;
        if (in_req_ready !== 8'h01) begin
            failures++;
            $display("FAIL full_acc0 got=%h exp=01", in_req_ready);
        end
        tick();
        set_req(0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (in_req_ready !== 8'h02) begin
            failures++;
            $display("FAIL full_acc1 got=%h exp=02", in_req_ready);
        end
        tick();
        set_req(1, 1'b0, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_req_ready !== 8'h00) begin
                failures++;
                $display("FAIL full_blocked cyc=%0d got=%h exp=00", c, in_req_ready);
            end
            checks++;
            if (out_req_valid[0] !== 1'b1 || out_tag(0) !== {16'hA000, 2'd0}) begin
                failures++;
                $display("FAIL full_head_stable cyc=%0d got=%b/%h exp=1/%h", c, out_req_valid[0], out_tag(0), {16'hA000, 2'd0});
            end
            tick();
        end
        out_req_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_req_ready !== 8'h00) begin
            failures++;
            $display("FAIL full_release_ready got=%h exp=00", in_req_ready);
        end
        tick();
        #1;
        checks++;
        if (out_tag(0) !== {16'hA001, 2'd1}) begin
            failures++;
            $display("FAIL full_order1 got=%h exp=%h", out_tag(0), {16'hA001, 2'd1});
        end
        checks++;
        if (in_req_ready !== 8'h04) begin
            failures++;
            $display("FAIL full_resume got=%h exp=04", in_req_ready);
        end
        tick();
        set_req(2, 1'b0, 16'h0000);
        #1;
        checks++;
        if (out_req_valid[0] !== 1'b1 || out_tag(0) !== {16'hA002, 2'd2}) begin
            failures++;
            $display("FAIL full_order2 got=%b/%h exp=1/%h", out_req_valid[0], out_tag(0), {16'hA002, 2'd2});
        end
        tick();
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL full_drained got=%b exp=00", out_req_valid);
        end
    endtask

    task automatic test_rsp_route;
        out_rsp_valid = 2'b10;
        out_rsp_tag   = {{16'h0ABC, 2'd3}, {16'h5555, 2'd1}};
        out_rsp_data  = {32'hDEADBEEF, 32'h01234567};
        in_rsp_ready  = '1;
        #1;
        checks++;
        if (in_rsp_valid !== 8'h80) begin
            failures++;
            $display("FAIL rsp_valid got=%h exp=80", in_rsp_valid);
        end
        checks++;
        if (in_rsp_tag[7*TW +: TW] !== 16'h0ABC || in_rsp_data[7*DW +: DW] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rsp_payload got=%h/%h exp=0abc/deadbeef", in_rsp_tag[7*TW +: TW], in_rsp_data[7*DW +: DW]);
        end
        checks++;
        if (out_rsp_ready !== 2'b11) begin
            failures++;
            $display("FAIL rsp_ready_all got=%b exp=11", out_rsp_ready);
        end
        in_rsp_ready[7] = 1'b0;
        #1;
        checks++;
        if (out_rsp_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL rsp_stall got=%b exp=0", out_rsp_ready[1]);
        end
        in_rsp_ready  = 8'b1011_1101;
        out_rsp_valid = 2'b11;
        #1;
        checks++;
        if (out_rsp_ready !== 2'b10) begin
            failures++;
            $display("FAIL rsp_ready_sel got=%b exp=10", out_rsp_ready);
        end
        checks++;
        if (in_rsp_valid !== 8'h82 || in_rsp_tag[1*TW +: TW] !== 16'h5555) begin
            failures++;
            $display("FAIL rsp_both got=%h/%h exp=82/5555", in_rsp_valid, in_rsp_tag[1*TW +: TW]);
        end
        out_rsp_valid = '0;
        in_rsp_ready  = '1;
    endtask

    task automatic test_back_to_back;
        logic [TW-1:0] cur [4];
        logic [TW-1:0] next_tag;
        logic [TW-1:0] prev_tag;
        int            prev_l;
        do_reset();
        next_tag = 16'h2000;
        prev_tag = '0;
        prev_l   = 0;
        for (int l = 0; l < 4; l++) begin
            cur[l]   = next_tag;
            next_tag = next_tag + 16'd1;
            set_req(4 + l, 1'b1, cur[l]);
        end
        for (int c = 0; c <= 100; c++) begin
            #1;
            if (c < 100) begin
                checks++;
                if (in_req_ready !== 8'(16 << (c % 4))) begin
                    failures++;
                    $display("FAIL b2b_ready cyc=%0d got=%h exp=%h", c, in_req_ready, 8'(16 << (c % 4)));
                end
            end
            if (c > 0) begin
                checks++;
                if (out_req_valid !== 2'b10 || out_tag(1) !== {prev_tag, SW'(prev_l)}) begin
                    failures++;
                    $display("FAIL b2b_out cyc=%0d got=%b/%h exp=10/%h", c, out_req_valid, out_tag(1), {prev_tag, SW'(prev_l)});
                end
            end
            if (c < 100) begin
                prev_tag = cur[c % 4];
                prev_l   = c % 4;
                tick();
                cur[c % 4] = next_tag;
                next_tag   = next_tag + 16'd1;
                set_req(4 + (c % 4), 1'b1, cur[c % 4]);
            end
        end
        for (int l = 0; l < 4; l++) set_req(4 + l, 1'b0, 16'h0000);
        tick();
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL b2b_drained got=%b exp=00", out_req_valid);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_req_ready = 2'b00;
        set_req(0, 1'b1, 16'hB000);
        set_req(1, 1'b1, 16'hB001);
        set_req(4, 1'b1, 16'hB004);
        set_req(5, 1'b1, 16'hB005);
        tick();
        set_req(0, 1'b0, 16'h0000);
        set_req(4, 1'b0, 16'h0000);
        tick();
        #1;
        checks++;
        if (out_req_valid !== 2'b11 || in_req_ready !== 8'h00) begin
            failures++;
            $display("FAIL mid_full got=%b/%h exp=11/00", out_req_valid, in_req_ready);
        end
        set_req(1, 1'b0, 16'h0000);
        set_req(5, 1'b0, 16'h0000);
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (out_req_valid !== 2'b00) begin
            failures++;
            $display("FAIL mid_async_drop got=%b exp=00", out_req_valid);
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'hC000 + 16'(i));
        set_req(5, 1'b1, 16'hC005);
        set_req(6, 1'b1, 16'hC006);
        out_req_ready = '1;
        tick();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (in_req_ready !== 8'h00) begin
            failures++;
            $display("FAIL mid_release_ready got=%h exp=00", in_req_ready);
        end
        tick();
        checks++;
        if (in_req_ready !== 8'h21) begin
            failures++;
            $display("FAIL mid_priority got=%h exp=21", in_req_ready);
        end
        init_inputs();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full();
        test_rsp_route();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
